// File: rtl/sync_fifo_flags_if.sv
// Handshake/bus bundle for sync_fifo_flags: write side, read side, status and error flags.
// Latency: none (wires only).
// Backpressure: producers watch full, consumers watch empty/valid; both modports see every flag.
//
// master : the datapath stage(s) driving the FIFO (write/read requests, clr_err)
// slave  : the FIFO itself (data_out, valid, occupancy and error flags)
interface sync_fifo_flags_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   logic                    w_en;
   logic [DATA_WIDTH-1:0]   data_in;
   logic                    r_en;
   logic                    clr_err;
   logic [DATA_WIDTH-1:0]   data_out;
   logic                    valid;
   logic                    full;
   logic                    empty;
   logic                    almost_full;
   logic                    almost_empty;
   logic [$clog2(DEPTH):0]  count;
   logic                    overflow;
   logic                    underflow;

   modport master (
      output w_en, data_in, r_en, clr_err,
      input  data_out, valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  w_en, data_in, r_en, clr_err,
      output data_out, valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Latency: flags/count 1 cycle after the accepting edge; read data 1 cycle (FWFT=0) or 0 cycles (FWFT=1).
// Backpressure: writes while full and reads while empty are dropped and latch overflow/underflow.
//
// Ports: clk (only clock), rst (async active-high), bus (sync_fifo_flags_if.slave):
//   w_en/data_in push, r_en pop, clr_err clears the sticky errors,
//   data_out/valid read data, full/empty/almost_full/almost_empty/count status,
//   overflow/underflow sticky errors.
// The bus instance must be built with the same DATA_WIDTH and DEPTH as this module.
module sync_fifo_flags #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,   // power of two, >= 2
   parameter int AF_LEVEL   = 14,   // 1..DEPTH
   parameter int AE_LEVEL   = 2,    // 0..DEPTH-1
   parameter bit FWFT       = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   sync_fifo_flags_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_TH    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_TH    = (AW+1)'(AE_LEVEL);

   // Pointers carry one extra wrap bit so that full (DEPTH) and empty (0)
   // are distinguishable by plain modular subtraction.
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [AW:0]           count_i;
   logic                  full_i;
   logic                  empty_i;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  overflow_q;
   logic                  underflow_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign count_i = wr_ptr - rd_ptr;
   assign full_i  = (count_i == FULL_CNT);
   assign empty_i = (count_i == '0);

   // Acceptance only looks at registered state, so a simultaneous read
   // never frees space for a write in the same cycle (and vice versa).
   assign wr_acc = bus.w_en && !full_i;
   assign rd_acc = bus.r_en && !empty_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage is deliberately not reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.data_in;
   end

   // Sticky errors: a new error in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.w_en && full_i)      overflow_q <= 1'b1;
         else if (bus.clr_err)        overflow_q <= 1'b0;

         if (bus.r_en && empty_i)     underflow_q <= 1'b1;
         else if (bus.clr_err)        underflow_q <= 1'b0;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word shown directly; forced to zero while empty so the
         // output has a defined value straight out of reset.
         assign bus.data_out = empty_i ? '0 : mem[rd_ptr[AW-1:0]];
         assign bus.valid    = !empty_i;
      end else begin : g_reg
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  valid_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dout_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_acc;
               if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
            end
         end

         assign bus.data_out = dout_q;
         assign bus.valid    = valid_q;
      end
   endgenerate

   assign bus.full         = full_i;
   assign bus.empty        = empty_i;
   assign bus.almost_full  = (count_i >= AF_TH);
   assign bus.almost_empty = (count_i <= AE_TH);
   assign bus.count        = count_i;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO: the next generation of the team's synchronous FIFO. Adds a full-range occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags with a clear input. A compile-time mode selects a registered-read output or a first-word-fall-through (FWFT) output. Sits between same-clock producer and consumer stages in the datapath; memory infers as registers or distributed RAM.

## Interface
- DATA_WIDTH, 8: word width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_LEVEL, 14: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 = registered read; 1 = first-word-fall-through.

- clk  in  1  the only clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data, sampled when the write is accepted.
- r_en  in  1  read request (pop).
- data_out  out  DATA_WIDTH  read data.
- valid  out  1  data_out holds a valid word.
- full, empty  out  1 each  occupancy flags.
- almost_full, almost_empty  out  1 each  threshold flags.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow, underflow  out  1 each  sticky error flags.
- clr_err  in  1  synchronous clear of overflow and underflow.

## Operation
- Write and read pointers are $clog2(DEPTH)+1 bits wide. The low bits address the memory; the MSB is a wrap bit. count = wr_ptr − rd_ptr, computed modulo 2^(AW+1).
- full = (count == DEPTH). empty = (count == 0). almost_full = (count ≥ AF_LEVEL). almost_empty = (count ≤ AE_LEVEL). All flags are decoded from the registered pointers only; no input feeds a flag combinationally.
- Write accepted when w_en && !full: mem[wr_ptr] ← data_in, then wr_ptr increments.
- Read accepted when r_en && !empty: rd_ptr increments.
- Simultaneous w_en and r_en:
  - Neither full nor empty: both are accepted and count is unchanged.
  - When full: the read is accepted and the write is rejected.
  - When empty: the write is accepted and the read is rejected.
- Pointers wrap naturally at 2^(AW+1). Memory address wraps from DEPTH−1 to 0.
- overflow sets on any cycle with w_en && full. underflow sets on any cycle with r_en && empty. Both hold until clr_err or rst. If clr_err and a new error coincide, the set wins.
- FWFT=0: on an accepted read, data_out ← mem[rd_ptr] and valid = 1 on the next cycle. Otherwise valid = 0 and data_out holds its last value.
- FWFT=1: data_out = mem[rd_ptr] combinationally and valid = !empty. An accepted read advances to the next word in the same cycle.
- Memory contents are not reset. A rejected write leaves memory and wr_ptr unchanged.

## Timing
- Reset values:
  - Pointers, count, data_out, valid, overflow, underflow: all 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
- Reset asserted mid-operation clears all state immediately, with no clock required. Words in flight are discarded.
- Flag and count latency: updated in the cycle after the accepted write or read edge.
- FWFT=0 read latency: 1 cycle from the r_en edge to valid data_out.
- FWFT=1 read latency: a word written at edge N is visible on data_out after edge N, with valid = 1.
- A write into an empty FIFO can be read at the earliest on the following cycle; there is no same-cycle bypass.

## Test plan
- Reset, then check outputs: empty=1, almost_empty=1, full=0, count=0, valid=0, data_out=0, error flags 0.
- DEPTH=16, write 0x00..0x0F: almost_full rises when count=14, full rises when count=16. Then read 16 words (FWFT=0): data_out = 0x00..0x0F, each 1 cycle after its r_en, and empty=1 at the end.
- When full, assert w_en=r_en=1 with data_in=0xAA: count stays 16 then drops to 15, 0xAA is not stored, overflow=1. Pulse clr_err: overflow=0.
- When empty, assert w_en=r_en=1 with data_in=0x55: count=1, underflow=1, and the next read returns 0x55.
- Wrap: write and read 40 words continuously at count≈8: all data returns in order and count is never out of range.
- FWFT=1: a single write of 0x3C gives data_out=0x3C and valid=1 the next cycle. Assert rst asynchronously mid-stream: all outputs reach reset values before the next clk edge.
